mem_req_arbiter: RTL
====================

// Module: mem_req_arbiter
// PURPOSE
// - Sits directly below the Blimp top level: merges the core's two memory clients (instruction fetch, data load/store) onto one memory port.
// - Round-robin request arbitration with per-client outstanding-request credits.
// - Tags each forwarded request with its source; steers responses back to the owning client through per-client response buffers.
// PARAMETERS
// - p_opaq_bits        8  client opaque width; memory-side opaque is p_opaq_bits+1 (MSB = source)
// - p_max_outstanding  2  max in-flight requests per client (>=1)
// PORTS
// - clk                       in   1     clock
// - rst                       in   1     synchronous, active-high reset
// - cli_req_val[2]            in   1     request valid; index 0 = inst, 1 = data
// - cli_req_rdy[2]            out  1     request ready
// - cli_req_op[2]             in   1     0 = read, 1 = write
// - cli_req_opaque[2]         in   p_opaq_bits  client tag
// - cli_req_addr[2]           in   32    byte address
// - cli_req_strb[2]           in   4     write byte strobes
// - cli_req_data[2]           in   32    write data
// - cli_resp_val[2]           out  1     response valid
// - cli_resp_rdy[2]           in   1     response ready
// - cli_resp_op / opaque / data [2]  out  1 / p_opaq_bits / 32  returned fields
// - mem_req_val / rdy         out / in  1   memory request handshake
// - mem_req_op, addr, strb, data  out  1, 32, 4, 32  forwarded request fields
// - mem_req_opaque            out  p_opaq_bits+1  {src, client opaque}
// - mem_resp_val / rdy        in / out  1   memory response handshake
// - mem_resp_op, opaque, data in   1, p_opaq_bits+1, 32  response fields
// BEHAVIOUR
// - Transfer fires when val && rdy in the same cycle. rdy may depend on val; val never depends on rdy.
// - Eligible(i) = cli_req_val[i] && credits(i) < p_max_outstanding.
// - Grant: round-robin over eligible clients; preference goes to the client not granted last.
// - prio_reg (1 bit, last granted source) updates only on a mem_req fire.
// - Request path is combinational, 0 cycles:
//   - mem_req_val = any eligible
//   - fields muxed from the granted client
//   - cli_req_rdy[i] = granted(i) && mem_req_rdy
//   - the non-granted client's rdy is 0
// - credits(i) is a counter of width $clog2(p_max_outstanding+1):
//   - +1 on cli_req fire(i)
//   - -1 on cli_resp fire(i)
//   - both in the same cycle -> unchanged
//   - never wraps
// - Responses:
//   - mem_resp_opaque MSB selects destination buffer src; the low bits are returned unchanged as cli_resp_opaque.
//   - Each client has a 2-entry FIFO response buffer.
//   - mem_resp_rdy = (count(src) < 2); no same-cycle pass-through when full.
//   - Enqueued data is visible at cli_resp the cycle after enqueue (1-cycle latency).
//   - A back-to-back stream sustains 1 response/cycle.
//   - A stalled client (resp_rdy=0) never blocks responses to the other client.
// - Simultaneous enqueue and dequeue on a buffer holding 1 entry: count stays 1, order preserved.
// - Enqueue on a full buffer is impossible (rdy=0).
// - Reset (any cycle, including mid-transaction):
//   - all buffers empty; credits = 0; prio_reg = data, so inst wins the first tie
//   - cli_resp_val = 0, mem_req_val = 0, mem_resp_rdy = 1
//   - in-flight memory responses after reset are the environment's responsibility
// - Sim-only assertions (ifndef SYNTHESIS):
//   - response arriving for a client with credits == 0
//   - credit counter overflow
// - Trace function returns "I>"/"D>" on request fire, "<I"/"<D" on response fire, blanks otherwise.
// STRUCTURE
// - Shared package (defs/UArch.v): MEM_SRC_INST = 1'b0, MEM_SRC_DATA = 1'b1 constants; mem_op read/write encoding.
// - Sub-module mem_arb_resp_buf: 2-entry response FIFO (val/rdy in and out, 1+p_opaq_bits+32 payload), instantiated per client.
// - Top holds: arbiter, prio_reg, credit counters, response steering.
// TESTING
// - Inst read only:
//   - addr 0x200, opaque 0x05 -> mem_req_opaque 0x005 same cycle
//   - mem resp data 0xDEADBEEF -> cli_resp[0] data 0xDEADBEEF, opaque 0x05, one cycle later
// - Both clients valid every cycle, mem_req_rdy=1 -> grants alternate I,D,I,D starting with I after reset.
//   - Two credit-limited clients: each stalls at 2 outstanding until a response fires.
// - Data client resp_rdy=0, two data resps buffered:
//   - third data resp -> mem_resp_rdy=0
//   - an inst resp is still accepted and delivered
// - Same cycle: credits(1) 1->1 via req fire + resp fire; buffer count 1->1; FIFO order of 3 responses 0xA,0xB,0xC preserved.
// - Assert rst mid-burst (2 outstanding each) -> next cycle all val low, credits 0, mem_resp_rdy 1; next tie granted to inst.
// - mem_req_rdy=0 for 5 cycles with both valid -> no rdy to either client, prio_reg unchanged, fields held stable.

Source files
------------

// File: rtl/mem_req_arbiter_pkg.sv
// Shared definitions for the two-client memory request arbiter.
// Source tags and memory op encodings used on the merged port.
package mem_req_arbiter_pkg;

  localparam logic MEM_SRC_INST = 1'b0;
  localparam logic MEM_SRC_DATA = 1'b1;

  localparam logic MEM_OP_READ  = 1'b0;
  localparam logic MEM_OP_WRITE = 1'b1;

  function automatic int unsigned credit_w(
    input int unsigned max_out
  );
    return $clog2(max_out + 1);
  endfunction

endpackage

// File: rtl/mem_arb_resp_buf.sv
// Two-entry response FIFO; output is registered so an enqueue
// shows up one cycle later, and a full buffer refuses input.
module mem_arb_resp_buf #(
  parameter int unsigned p_w = 41
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_val,
  output logic           in_rdy,
  input  logic [p_w-1:0] in_msg,
  output logic           out_val,
  input  logic           out_rdy,
  output logic [p_w-1:0] out_msg
);

  logic [p_w-1:0] ent_q [2];
  logic [p_w-1:0] ent_d [2];
  logic           wr_ptr_q, wr_ptr_d;
  logic           rd_ptr_q, rd_ptr_d;
  logic [1:0]     cnt_q, cnt_d;
  logic           enq, deq;

  assign in_rdy  = (cnt_q != 2'd2);
  assign out_val = (cnt_q != 2'd0);
  assign out_msg = ent_q[rd_ptr_q];
  assign enq     = in_val && in_rdy;
  assign deq     = out_val && out_rdy;

  always_comb begin
    ent_d    = ent_q;
    wr_ptr_d = wr_ptr_q ^ enq;
    rd_ptr_d = rd_ptr_q ^ deq;
    cnt_d    = cnt_q;
    if (enq) ent_d[wr_ptr_q] = in_msg;
    case ({enq, deq})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    ent_q <= ent_d;
  end

endmodule

// File: rtl/mem_req_arbiter.sv
// Merges inst/data memory clients onto one port: round-robin
// grant with per-client credits, source-tagged response steering.
module mem_req_arbiter
  import mem_req_arbiter_pkg::*;
#(
  parameter int unsigned p_opaq_bits       = 8,
  parameter int unsigned p_max_outstanding = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [1:0]             cli_req_val,
  output logic [1:0]             cli_req_rdy,
  input  logic [1:0]             cli_req_op,
  input  logic [p_opaq_bits-1:0] cli_req_opaque [2],
  input  logic [31:0]            cli_req_addr [2],
  input  logic [3:0]             cli_req_strb [2],
  input  logic [31:0]            cli_req_data [2],
  output logic [1:0]             cli_resp_val,
  input  logic [1:0]             cli_resp_rdy,
  output logic [1:0]             cli_resp_op,
  output logic [p_opaq_bits-1:0] cli_resp_opaque [2],
  output logic [31:0]            cli_resp_data [2],
  output logic                   mem_req_val,
  input  logic                   mem_req_rdy,
  output logic                   mem_req_op,
  output logic [31:0]            mem_req_addr,
  output logic [3:0]             mem_req_strb,
  output logic [31:0]            mem_req_data,
  output logic [p_opaq_bits:0]   mem_req_opaque,
  input  logic                   mem_resp_val,
  output logic                   mem_resp_rdy,
  input  logic                   mem_resp_op,
  input  logic [p_opaq_bits:0]   mem_resp_opaque,
  input  logic [31:0]            mem_resp_data
);

  localparam int unsigned CW = credit_w(p_max_outstanding);
  localparam int unsigned PW = 1 + p_opaq_bits + 32;
  localparam logic [CW-1:0] MAX_C = CW'(p_max_outstanding);

  logic [CW-1:0] credits_q [2];
  logic [CW-1:0] credits_d [2];
  logic          prio_q, prio_d;
  logic [1:0]    elig, gnt, req_fire, resp_fire;
  logic          gnt_src, mem_req_fire, resp_src;
  logic [1:0]    buf_in_val, buf_in_rdy;
  logic [PW-1:0] buf_in_msg;
  logic [PW-1:0] buf_out_msg [2];

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      elig[i] = !rst && cli_req_val[i] && (credits_q[i] < MAX_C);
    end
    // On a tie the client that did not win last time goes first
    if (&elig)       gnt_src = ~prio_q;
    else if (elig[1]) gnt_src = MEM_SRC_DATA;
    else             gnt_src = MEM_SRC_INST;
  end

  assign mem_req_val    = |elig;
  assign gnt            = mem_req_val ? (2'b01 << gnt_src) : 2'b00;
  assign cli_req_rdy    = gnt & {2{mem_req_rdy}};
  assign req_fire       = cli_req_val & cli_req_rdy;
  assign mem_req_fire   = mem_req_val && mem_req_rdy;
  assign mem_req_op     = cli_req_op[gnt_src];
  assign mem_req_addr   = cli_req_addr[gnt_src];
  assign mem_req_strb   = cli_req_strb[gnt_src];
  assign mem_req_data   = cli_req_data[gnt_src];
  assign mem_req_opaque = {gnt_src, cli_req_opaque[gnt_src]};
  assign prio_d         = mem_req_fire ? gnt_src : prio_q;

  assign resp_src     = mem_resp_opaque[p_opaq_bits];
  assign mem_resp_rdy = buf_in_rdy[resp_src];
  assign buf_in_msg   = {mem_resp_op,
                         mem_resp_opaque[p_opaq_bits-1:0],
                         mem_resp_data};
  assign resp_fire    = cli_resp_val & cli_resp_rdy;

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      credits_d[i] = credits_q[i];
      if (req_fire[i] && !resp_fire[i] && credits_q[i] != MAX_C)
        credits_d[i] = credits_q[i] + CW'(1);
      else if (!req_fire[i] && resp_fire[i] && credits_q[i] != '0)
        credits_d[i] = credits_q[i] - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prio_q <= MEM_SRC_DATA;
      for (int i = 0; i < 2; i++) credits_q[i] <= '0;
    end else begin
      prio_q <= prio_d;
      for (int i = 0; i < 2; i++) credits_q[i] <= credits_d[i];
    end
  end

  for (genvar g = 0; g < 2; g++) begin : g_buf
    assign buf_in_val[g] = mem_resp_val && (resp_src == 1'(g));

    mem_arb_resp_buf #(
      .p_w (PW)
    ) u_buf (
      .clk     (clk),
      .rst     (rst),
      .in_val  (buf_in_val[g]),
      .in_rdy  (buf_in_rdy[g]),
      .in_msg  (buf_in_msg),
      .out_val (cli_resp_val[g]),
      .out_rdy (cli_resp_rdy[g]),
      .out_msg (buf_out_msg[g])
    );

    assign cli_resp_op[g]     = buf_out_msg[g][PW-1];
    assign cli_resp_opaque[g] = buf_out_msg[g][PW-2 -: p_opaq_bits];
    assign cli_resp_data[g]   = buf_out_msg[g][31:0];
  end

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 2; i++) begin
        assert (!(buf_in_val[i] && mem_resp_rdy && credits_q[i] == '0))
          else $error("response for client %0d with no credit", i);
        assert (!(req_fire[i] && !resp_fire[i] && credits_q[i] == MAX_C))
          else $error("credit overflow on client %0d", i);
      end
    end
  end

  function automatic string trace();
    string s_req, s_rsp;
    s_req = "  ";
    s_rsp = "  ";
    if (mem_req_fire) s_req = (gnt_src == MEM_SRC_DATA) ? "D>" : "I>";
    if (resp_fire[0])      s_rsp = "<I";
    else if (resp_fire[1]) s_rsp = "<D";
    return {s_req, " ", s_rsp};
  endfunction
`endif

endmodule
